exe_md_stage: RTL and testbench

EXE_MD_STAGE -- requirements
Module: exe_md_stage

---
 rtl/exe_md_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_exe_md_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exe_md_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, and an iterative
// multiply/divide unit that delivers its results through HI/LO.
module exe_md_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FREEZE,
    input  logic            in_valid,
    input  logic [3:0]      op,
    input  logic [REGW-1:0] rs_idx,
    input  logic [REGW-1:0] rt_idx,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    input  logic [5:0]      shamt,
    input  logic [REGW-1:0] dst_idx,
    input  logic            do_wb,
    input  logic            mem_wb,
    input  logic            wb_wb,
    input  logic [REGW-1:0] mem_dst,
    input  logic [REGW-1:0] wb_dst,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_out,
    output logic            valid_PR,
    output logic            wb_PR,
    output logic [REGW-1:0] dst_PR,
    output logic [XLEN-1:0] res_PR,
    output logic [XLEN-1:0] store_PR,
    output logic            md_busy,
    output logic            div_zero
);
    localparam int CNTW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULT = 4'd10;
    localparam logic [3:0] OP_MULTU= 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_MFHI = 4'd14;
    localparam logic [3:0] OP_MFLO = 4'd15;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} md_state_t;

    // MEM stage has priority over WB; register 0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REGW-1:0] idx,    input logic [XLEN-1:0] rf_val,
        input logic            m_wb,   input logic [REGW-1:0] m_dst, input logic [XLEN-1:0] m_data,
        input logic            w_wb,   input logic [REGW-1:0] w_dst, input logic [XLEN-1:0] w_data);
        logic [XLEN-1:0] res;
        if (m_wb && (m_dst == idx) && (idx != {REGW{1'b0}})) begin
            res = m_data;
        end else if (w_wb && (w_dst == idx) && (idx != {REGW{1'b0}})) begin
            res = w_data;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    md_state_t         md_state_r;
    logic [CNTW-1:0]   cnt_r;
    logic [2*XLEN-1:0] wk_r;
    logic [XLEN-1:0]   dvs_r, hi_r, lo_r;
    logic              is_div_r, neg_q_r, neg_r_r, dz_r;

    logic [XLEN-1:0]   op_a_s, fwd_b_s, op_b_s, alu_res_s, abs_a_s, abs_b_s;
    logic [5:0]        sh_amt_s;
    logic              is_md_s, md_start_s, a_neg_s, b_neg_s;
    logic [XLEN:0]     mul_sum_s, div_diff_s;
    logic [2*XLEN-1:0] mul_next_s, div_sh_s, div_next_s, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    assign op_a_s   = fwd_sel(rs_idx, rs_val, mem_wb, mem_dst, mem_data, wb_wb, wb_dst, wb_data);
    assign fwd_b_s  = fwd_sel(rt_idx, rt_val, mem_wb, mem_dst, mem_data, wb_wb, wb_dst, wb_data);
    assign op_b_s   = use_imm ? imm : fwd_b_s;
    assign sh_amt_s = shamt & 6'(XLEN - 1);

    assign is_md_s    = in_valid && (op >= OP_MULT) && (op <= OP_DIVU);
    assign md_start_s = is_md_s && !FREEZE && (md_state_r == ST_IDLE);
    assign stall_out  = in_valid && md_busy && (op >= OP_MULT);

    // Iterative unit works on magnitudes; signs are restored in DONE.
    assign a_neg_s = ~op[0] & op_a_s[XLEN-1];
    assign b_neg_s = ~op[0] & op_b_s[XLEN-1];
    assign abs_a_s = a_neg_s ? -op_a_s : op_a_s;
    assign abs_b_s = b_neg_s ? -op_b_s : op_b_s;

    assign mul_sum_s  = {1'b0, wk_r[2*XLEN-1:XLEN]} + (wk_r[0] ? {1'b0, dvs_r} : {(XLEN+1){1'b0}});
    assign mul_next_s = {mul_sum_s, wk_r[XLEN-1:1]};
    assign div_sh_s   = {wk_r[2*XLEN-2:0], 1'b0};
    assign div_diff_s = {wk_r[2*XLEN-1], div_sh_s[2*XLEN-1:XLEN]} - {1'b0, dvs_r};
    assign div_next_s = div_diff_s[XLEN] ? div_sh_s : {div_diff_s[XLEN-1:0], div_sh_s[XLEN-1:1], 1'b1};

    assign prod_s = neg_q_r ? -wk_r : wk_r;
    assign quo_s  = dz_r ? {XLEN{1'b1}} : (neg_q_r ? -wk_r[XLEN-1:0] : wk_r[XLEN-1:0]);
    assign rem_s  = neg_r_r ? -wk_r[2*XLEN-1:XLEN] : wk_r[2*XLEN-1:XLEN];

    // Single-cycle ALU.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (op)
            OP_ADD:  alu_res_s = op_a_s + op_b_s;
            OP_SUB:  alu_res_s = op_a_s - op_b_s;
            OP_AND:  alu_res_s = op_a_s & op_b_s;
            OP_OR:   alu_res_s = op_a_s | op_b_s;
            OP_XOR:  alu_res_s = op_a_s ^ op_b_s;
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            OP_SLL:  alu_res_s = op_b_s << sh_amt_s;
            OP_SRL:  alu_res_s = op_b_s >> sh_amt_s;
            OP_SRA:  alu_res_s = $signed(op_b_s) >>> sh_amt_s;
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Multiply/divide sequencer and HI/LO registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            md_state_r <= ST_IDLE;
            cnt_r      <= {CNTW{1'b0}};
            wk_r       <= {(2*XLEN){1'b0}};
            dvs_r      <= {XLEN{1'b0}};
            hi_r       <= {XLEN{1'b0}};
            lo_r       <= {XLEN{1'b0}};
            is_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            dz_r       <= 1'b0;
            md_busy    <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            case (md_state_r)
                ST_IDLE: begin
                    div_zero <= 1'b0;
                    if (md_start_s) begin
                        md_state_r <= ST_BUSY;
                        cnt_r      <= CNTW'(XLEN - 1);
                        wk_r       <= {{XLEN{1'b0}}, abs_a_s};
                        dvs_r      <= abs_b_s;
                        is_div_r   <= op[2];
                        neg_q_r    <= a_neg_s ^ b_neg_s;
                        neg_r_r    <= a_neg_s;
                        dz_r       <= (op_b_s == {XLEN{1'b0}});
                        md_busy    <= 1'b1;
                    end else begin
                        md_busy    <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    wk_r <= is_div_r ? div_next_s : mul_next_s;
                    if (cnt_r == {CNTW{1'b0}}) begin
                        md_state_r <= ST_DONE;
                        div_zero   <= is_div_r & dz_r;
                    end else begin
                        cnt_r      <= cnt_r - CNTW'(1);
                    end
                end
                ST_DONE: begin
                    hi_r       <= is_div_r ? rem_s : prod_s[2*XLEN-1:XLEN];
                    lo_r       <= is_div_r ? quo_s : prod_s[XLEN-1:0];
                    md_state_r <= ST_IDLE;
                    md_busy    <= 1'b0;
                    div_zero   <= 1'b0;
                end
                default: begin
                    md_state_r <= ST_IDLE;
                    md_busy    <= 1'b0;
                    div_zero   <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline register: hold on FREEZE, bubble on idle or stall.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_PR <= 1'b0;
            wb_PR    <= 1'b0;
            dst_PR   <= {REGW{1'b0}};
            res_PR   <= {XLEN{1'b0}};
            store_PR <= {XLEN{1'b0}};
        end else if (!FREEZE) begin
            if (!in_valid || stall_out) begin
                valid_PR <= 1'b0;
                wb_PR    <= 1'b0;
            end else begin
                valid_PR <= 1'b1;
                dst_PR   <= dst_idx;
                store_PR <= fwd_b_s;
                case (op)
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        res_PR <= {XLEN{1'b0}};
                        wb_PR  <= 1'b0;
                    end
                    OP_MFHI: begin
                        res_PR <= hi_r;
                        wb_PR  <= do_wb;
                    end
                    OP_MFLO: begin
                        res_PR <= lo_r;
                        wb_PR  <= do_wb;
                    end
                    default: begin
                        res_PR <= alu_res_s;
                        wb_PR  <= do_wb;
                    end
                endcase
            end
        end else begin
            valid_PR <= valid_PR;
        end
    end
endmodule

// File: tb/tb_exe_md_stage.sv
// Directed bench for exe_md_stage: forwarding, ALU ops, multiply/divide timing,
// divide by zero, reset during an operation and FREEZE behaviour.
module tb_exe_md_stage;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    logic            CLK, RESET, FREEZE, in_valid, use_imm, do_wb, mem_wb, wb_wb;
    logic [3:0]      op;
    logic [REGW-1:0] rs_idx, rt_idx, dst_idx, mem_dst, wb_dst;
    logic [XLEN-1:0] rs_val, rt_val, imm, mem_data, wb_data;
    logic [5:0]      shamt;
    logic            stall_out, valid_PR, wb_PR, md_busy, div_zero;
    logic [REGW-1:0] dst_PR;
    logic [XLEN-1:0] res_PR, store_PR;

    int checks = 0;
    int failures = 0;

    exe_md_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .in_valid(in_valid), .op(op),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .rs_val(rs_val), .rt_val(rt_val),
        .imm(imm), .use_imm(use_imm), .shamt(shamt), .dst_idx(dst_idx), .do_wb(do_wb),
        .mem_wb(mem_wb), .wb_wb(wb_wb), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .mem_data(mem_data), .wb_data(wb_data), .stall_out(stall_out),
        .valid_PR(valid_PR), .wb_PR(wb_PR), .dst_PR(dst_PR), .res_PR(res_PR),
        .store_PR(store_PR), .md_busy(md_busy), .div_zero(div_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; op = 4'd0; rs_idx = '0; rt_idx = '0; rs_val = '0; rt_val = '0;
        imm = '0; use_imm = 1'b0; shamt = 6'd0; dst_idx = '0; do_wb = 1'b0;
        mem_wb = 1'b0; wb_wb = 1'b0; mem_dst = '0; wb_dst = '0; mem_data = '0; wb_data = '0;
    endtask

    task automatic issue_rr(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] sh);
        in_valid = 1'b1; op = o; rs_idx = 5'd1; rt_idx = 5'd2; rs_val = a; rt_val = b;
        shamt = sh; use_imm = 1'b0; do_wb = 1'b1; dst_idx = 5'd3; mem_wb = 1'b0; wb_wb = 1'b0;
    endtask

    task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_dz);
        int n;
        int dz;
        n = 0;
        dz = 0;
        issue_rr(o, a, b, 6'd0);
        step();
        check({tag, "_busy"}, md_busy, 1);
        check({tag, "_pr_wb"}, {valid_PR, wb_PR}, 2'b10);
        in_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            n = i;
            if (div_zero) dz++;
            if (!md_busy) break;
        end
        check({tag, "_latency"}, n, 33);
        check({tag, "_dz"}, dz, exp_dz);
        issue_rr(4'd14, 32'd0, 32'd0, 6'd0);
        step();
        check({tag, "_hi"}, res_PR, exp_hi);
        check({tag, "_mfhi_wb"}, wb_PR, 1);
        op = 4'd15;
        step();
        check({tag, "_lo"}, res_PR, exp_lo);
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        RESET = 1'b0;
        FREEZE = 1'b0;
        idle_inputs();
        #12;
        check("rst_res", res_PR, 0);
        check("rst_flags", {valid_PR, wb_PR, md_busy, div_zero}, 4'b0000);
        check("rst_dst_store", {dst_PR, store_PR}, 0);
        RESET = 1'b1;
        step();

        // MEM forwarding wins over WB for both operands
        in_valid = 1'b1; op = 4'd0; rs_idx = 5'd5; rt_idx = 5'd5;
        rs_val = 32'h100; rt_val = 32'h100; do_wb = 1'b1; dst_idx = 5'd9;
        mem_wb = 1'b1; mem_dst = 5'd5; mem_data = 32'h10;
        wb_wb = 1'b1; wb_dst = 5'd5; wb_data = 32'h20;
        step();
        check("add_fwd", res_PR, 32'h20);
        check("add_fwd_pr", {valid_PR, wb_PR, dst_PR}, {2'b11, 5'd9});
        check("add_fwd_store", store_PR, 32'h10);

        rs_idx = 5'd0; rt_idx = 5'd0; mem_dst = 5'd0; wb_dst = 5'd0;
        rs_val = 32'd3; rt_val = 32'd4;
        step();
        check("add_r0", res_PR, 32'd7);
        check("add_r0_store", store_PR, 32'd4);

        op = 4'd1; rs_idx = 5'd6; rt_idx = 5'd7; rs_val = 32'h1000; rt_val = 32'h2000;
        mem_dst = 5'd7; mem_data = 32'h1; wb_dst = 5'd6; wb_data = 32'h55;
        step();
        check("sub_wbfwd", res_PR, 32'h54);

        op = 4'd0; mem_wb = 1'b0; wb_wb = 1'b0; rs_idx = 5'd1; rt_idx = 5'd2;
        rs_val = 32'd10; rt_val = 32'h99; imm = 32'd5; use_imm = 1'b1;
        step();
        check("add_imm", res_PR, 32'd15);
        check("imm_store", store_PR, 32'h99);

        issue_rr(4'd5, 32'hFFFFFFFF, 32'd1, 6'd0); step(); check("slt", res_PR, 32'd1);
        issue_rr(4'd6, 32'hFFFFFFFF, 32'd1, 6'd0); step(); check("sltu", res_PR, 32'd0);
        issue_rr(4'd9, 32'h80000000, 32'h80000000, 6'd36); step(); check("sra", res_PR, 32'hF8000000);
        issue_rr(4'd8, 32'h80000000, 32'h80000000, 6'd36); step(); check("srl", res_PR, 32'h08000000);
        issue_rr(4'd7, 32'd1, 32'd1, 6'd31); step(); check("sll", res_PR, 32'h80000000);
        issue_rr(4'd4, 32'hF0F0, 32'hFF00, 6'd0); step(); check("xor", res_PR, 32'h0FF0);
        issue_rr(4'd2, 32'hF0F0, 32'hFF00, 6'd0); step(); check("and", res_PR, 32'hF000);
        issue_rr(4'd3, 32'hF0F0, 32'hFF00, 6'd0); step(); check("or", res_PR, 32'hFFF0);
        issue_rr(4'd1, 32'd0, 32'd1, 6'd0); step(); check("sub_wrap", res_PR, 32'hFFFFFFFF);
        issue_rr(4'd0, 32'hFFFFFFFF, 32'd2, 6'd0); do_wb = 1'b0; step();
        check("add_wrap_nowb", {wb_PR, res_PR}, {1'b0, 32'd1});
        in_valid = 1'b0; step();
        check("bubble_idle", {valid_PR, wb_PR}, 2'b00);

        // MULT with MFHI waiting right behind it
        issue_rr(4'd10, 32'd7, 32'hFFFFFFFD, 6'd0);
        step();
        check("mult_busy", md_busy, 1);
        issue_rr(4'd14, 32'd0, 32'd0, 6'd0);
        #1;
        check("mfhi_stall", stall_out, 1);
        n = 0;
        bad = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            n = i;
            if (!stall_out) break;
            if (valid_PR || wb_PR) bad++;
        end
        check("stall_len", n, 33);
        check("stall_bubbles", bad, 0);
        step();
        check("mult_hi", res_PR, 32'hFFFFFFFF);
        op = 4'd15;
        step();
        check("mult_lo", res_PR, 32'hFFFFFFEB);
        in_valid = 1'b0;

        run_md("div", 4'd12, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_md("divu", 4'd13, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 0);
        run_md("divz", 4'd13, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1);
        run_md("div_negb", 4'd12, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0);
        run_md("multu", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 0);

        // Reset in the middle of a multiply
        issue_rr(4'd10, 32'd5, 32'd6, 6'd0);
        step();
        in_valid = 1'b0;
        repeat (10) step();
        #2 RESET = 1'b0;
        #1;
        check("rst_mid_busy", {md_busy, valid_PR}, 2'b00);
        #2 RESET = 1'b1;
        issue_rr(4'd14, 32'd0, 32'd0, 6'd0); step(); check("rst_hi_clr", res_PR, 32'd0);
        op = 4'd15; step(); check("rst_lo_clr", res_PR, 32'd0);
        in_valid = 1'b0;
        run_md("mult_after_rst", 4'd10, 32'd3, 32'd4, 32'd0, 32'd12, 0);

        // MD op presented under FREEZE is ignored and PR holds
        FREEZE = 1'b1;
        issue_rr(4'd10, 32'd2, 32'd3, 6'd0);
        step();
        check("frz_no_accept", md_busy, 0);
        check("frz_hold_idle", {valid_PR, res_PR}, {1'b1, 32'd12});
        FREEZE = 1'b0;

        // FREEZE during an ALU op while the unit keeps counting
        step();
        issue_rr(4'd0, 32'd1, 32'd2, 6'd0);
        #1;
        check("alu_no_stall", stall_out, 0);
        step();
        check("alu_while_busy", res_PR, 32'd3);
        FREEZE = 1'b1;
        issue_rr(4'd0, 32'd10, 32'd20, 6'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (res_PR !== 32'd3 || valid_PR !== 1'b1 || wb_PR !== 1'b1) bad++;
        end
        check("frz_hold", bad, 0);
        FREEZE = 1'b0;
        in_valid = 1'b0;
        n = 4;
        for (int i = 5; i <= 45; i++) begin
            step();
            n = i;
            if (!md_busy) break;
        end
        check("frz_fsm_latency", n, 33);
        issue_rr(4'd15, 32'd0, 32'd0, 6'd0);
        step();
        check("frz_mult_lo", res_PR, 32'd6);
        in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
